// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the micro-sequencer: branch modes, condition selects,
// ARM condition codes and microword field offsets.
package micro_sequencer_pkg;

  localparam logic [2:0] M_ZERO = 3'b000;
  localparam logic [2:0] M_MAP  = 3'b001;
  localparam logic [2:0] M_INC  = 3'b010;
  localparam logic [2:0] M_JMP  = 3'b011;
  localparam logic [2:0] M_CJMP = 3'b100;
  localparam logic [2:0] M_CMAP = 3'b101;
  localparam logic [2:0] M_CALL = 3'b110;
  localparam logic [2:0] M_RET  = 3'b111;

  localparam logic [1:0] CS_MFC   = 2'b00;
  localparam logic [1:0] CS_CPASS = 2'b01;
  localparam logic [1:0] CS_ONE   = 2'b10;
  localparam logic [1:0] CS_Z     = 2'b11;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Microword, MSB to LSB: mode[2:0], csel[1:0], inv, target[SW-1:0], ctrl[CW-1:0]
  function automatic int f_tgt_lsb(input int cw);
    return cw;
  endfunction

  function automatic int f_inv_pos(input int sw, input int cw);
    return cw + sw;
  endfunction

  function automatic int f_csel_lsb(input int sw, input int cw);
    return cw + sw + 1;
  endfunction

  function automatic int f_mode_lsb(input int sw, input int cw);
    return cw + sw + 3;
  endfunction

  function automatic int f_mw(input int sw, input int cw);
    return cw + sw + 6;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Host-side bundle of the micro-sequencer: decode/status inputs, control-store
// load port and the sequencer outputs. No handshake; everything is sampled each clk.
interface micro_sequencer_if
  import micro_sequencer_pkg::*;
#(
  parameter int SW = 6,
  parameter int CW = 45
);
  logic [31:0]             ir;
  logic [3:0]              flags;
  logic                    mfc;
  logic [SW-1:0]           map_addr;
  logic                    ld_en;
  logic [SW-1:0]           ld_addr;
  logic [f_mw(SW,CW)-1:0]  ld_data;
  logic [CW-1:0]           ctrl_out;
  logic [SW-1:0]           upc;
  logic                    stk_err;

  modport master (
    output ir, flags, mfc, map_addr, ld_en, ld_addr, ld_data,
    input  ctrl_out, upc, stk_err
  );

  modport slave (
    input  ir, flags, mfc, map_addr, ld_en, ld_addr, ld_data,
    output ctrl_out, upc, stk_err
  );
endinterface

// File: rtl/micro_sequencer_cond_eval.sv
// ARM condition-code check of cc_i against flags_i {N,Z,C,V}.
// Purely combinational, zero latency, no backpressure.
module micro_sequencer_cond_eval
  import micro_sequencer_pkg::*;
(
  input  logic [3:0] cc_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);
  logic n, z, c, v;

  assign {n, z, c, v} = flags_i;

  always_comb begin
    pass_o = 1'b0;
    case (cc_i)
      CC_EQ: pass_o = z;
      CC_NE: pass_o = ~z;
      CC_CS: pass_o = c;
      CC_CC: pass_o = ~c;
      CC_MI: pass_o = n;
      CC_PL: pass_o = ~n;
      CC_VS: pass_o = v;
      CC_VC: pass_o = ~v;
      CC_HI: pass_o = c & ~z;
      CC_LS: pass_o = ~c | z;
      CC_GE: pass_o = (n == v);
      CC_LT: pass_o = (n != v);
      CC_GT: pass_o = ~z & (n == v);
      CC_LE: pass_o = z | (n != v);
      CC_AL: pass_o = 1'b1;
      CC_NV: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer with writable control store, registered MIR and return stack.
// ctrl_out follows the chosen microaddress by one clk; never stalls, store writes included.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int SW  = 6,
  parameter int CW  = 45,
  parameter int STK = 4
) (
  input logic              clk,
  input logic              CLR,
  micro_sequencer_if.slave bus
);
  localparam int MW       = f_mw(SW, CW);
  localparam int TGT_LSB  = f_tgt_lsb(CW);
  localparam int INV_POS  = f_inv_pos(SW, CW);
  localparam int CSEL_LSB = f_csel_lsb(SW, CW);
  localparam int MODE_LSB = f_mode_lsb(SW, CW);
  localparam int DEPTH    = 2 ** SW;
  localparam int SPW      = $clog2(STK + 1);
  localparam int IW       = (STK > 1) ? $clog2(STK) : 1;

  logic [MW-1:0]  store_q [DEPTH];
  logic [SW-1:0]  stk_q   [STK];
  logic [MW-1:0]  mir_q;
  logic [SW-1:0]  upc_q, upc_d, upc_inc;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push;
  logic [IW-1:0]  wr_idx, rd_idx;
  logic           stk_full, stk_empty;

  logic [2:0]     mode;
  logic [1:0]     csel;
  logic           inv;
  logic [SW-1:0]  target;
  logic           cpass, sel, cond;
  logic           unused_ir;

  assign mode   = mir_q[MODE_LSB +: 3];
  assign csel   = mir_q[CSEL_LSB +: 2];
  assign inv    = mir_q[INV_POS];
  assign target = mir_q[TGT_LSB +: SW];

  assign unused_ir = ^bus.ir[27:0];

  micro_sequencer_cond_eval cond_eval (
    .cc_i    (bus.ir[31:28]),
    .flags_i (bus.flags),
    .pass_o  (cpass)
  );

  always_comb begin
    sel = 1'b1;
    case (csel)
      CS_MFC:   sel = bus.mfc;
      CS_CPASS: sel = cpass;
      CS_ONE:   sel = 1'b1;
      CS_Z:     sel = bus.flags[2];
    endcase
  end

  assign cond      = inv ^ sel;
  assign upc_inc   = upc_q + SW'(1);
  assign stk_full  = (sp_q == SPW'(STK));
  assign stk_empty = (sp_q == '0);
  assign wr_idx    = IW'(sp_q);
  assign rd_idx    = IW'(sp_q - SPW'(1));

  always_comb begin
    upc_d = upc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    case (mode)
      M_ZERO: upc_d = '0;
      M_MAP:  upc_d = bus.map_addr;
      M_INC:  upc_d = upc_inc;
      M_JMP:  upc_d = target;
      M_CJMP: upc_d = cond ? target : upc_inc;
      M_CMAP: upc_d = cond ? bus.map_addr : upc_inc;
      M_CALL: begin
        // Overflow still takes the jump; only the return address is lost.
        upc_d = target;
        if (stk_full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
        end
      end
      M_RET: begin
        if (stk_empty) begin
          upc_d = '0;
          err_d = 1'b1;
        end else begin
          upc_d = stk_q[rd_idx];
          sp_d  = sp_q - SPW'(1);
        end
      end
    endcase
  end

  // Store and stack bodies are not reset; an empty sp makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      store_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stk_q[wr_idx] <= upc_inc;
    end
  end

  // MIR reads store at the same edge a write may land: the old word is fetched.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      upc_q <= '0;
      mir_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      mir_q <= store_q[upc_d];
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign bus.ctrl_out = mir_q[CW-1:0];
  assign bus.upc      = upc_q;
  assign bus.stk_err  = err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: table-driven branch/condition vectors
// plus hand sequences for stack overflow/underflow, reset and load collision.
module tb_micro_sequencer;
  localparam int SW = 6;
  localparam int CW = 45;
  localparam int MW = CW + SW + 6;

  logic clk;
  logic CLR;
  int   n_vec;
  int   n_bad;

  micro_sequencer_if #(.SW(SW), .CW(CW)) bus ();

  micro_sequencer #(.SW(SW), .CW(CW), .STK(4)) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mfc;
    logic [3:0] fl;
    logic [3:0] cc;
    logic [5:0] map;
    logic [5:0] exp_upc;
    logic [7:0] exp_ctrl;
  } vec_t;

  typedef struct {
    logic [3:0] cc;
    logic [3:0] fl;
    logic       pass;
  } cc_t;

  vec_t vt[$];
  cc_t  ct[21];

  function automatic logic [MW-1:0] mw(input logic [2:0] mode, input logic [1:0] csel,
                                       input logic inv, input logic [5:0] tgt,
                                       input logic [7:0] ctrl);
    return {mode, csel, inv, tgt, 37'd0, ctrl};
  endfunction

  function automatic void add(input logic mfc, input logic [3:0] fl, input logic [3:0] cc,
                              input logic [5:0] map, input logic [5:0] eu, input logic [7:0] ec);
    vt.push_back('{mfc, fl, cc, map, eu, ec});
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [MW-1:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    step();
    bus.ld_en   = 1'b0;
  endtask

  initial begin
    logic [5:0] s_upc [13];
    logic       s_err [13];

    n_vec = 0;
    n_bad = 0;
    CLR          = 1'b0;
    bus.ir       = {4'hE, 28'h0ABCDEF};
    bus.flags    = 4'h0;
    bus.mfc      = 1'b0;
    bus.map_addr = '0;
    bus.ld_en    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;

    // Program A: branch modes and condition evaluation
    load(6'h00, mw(3'd2, 2'd0, 1'b0, 6'h00, 8'h05));
    load(6'h01, mw(3'd2, 2'd0, 1'b0, 6'h00, 8'h11));
    load(6'h02, mw(3'd4, 2'd0, 1'b1, 6'h02, 8'h22));
    load(6'h03, mw(3'd4, 2'd1, 1'b0, 6'h20, 8'h33));
    load(6'h04, mw(3'd5, 2'd3, 1'b0, 6'h00, 8'h44));
    load(6'h05, mw(3'd4, 2'd2, 1'b1, 6'h3F, 8'h55));
    load(6'h06, mw(3'd1, 2'd0, 1'b0, 6'h00, 8'h66));
    load(6'h08, mw(3'd4, 2'd1, 1'b0, 6'h28, 8'h08));
    load(6'h09, mw(3'd3, 2'd0, 1'b0, 6'h08, 8'h09));
    load(6'h10, mw(3'd3, 2'd0, 1'b0, 6'h04, 8'h10));
    load(6'h20, mw(3'd3, 2'd0, 1'b0, 6'h03, 8'h20));
    load(6'h28, mw(3'd3, 2'd0, 1'b0, 6'h08, 8'h28));
    load(6'h3F, mw(3'd2, 2'd0, 1'b0, 6'h00, 8'h3F));

    check("reset upc", 64'(bus.upc), 64'h0);
    check("reset ctrl_out", 64'(bus.ctrl_out), 64'h0);
    check("reset stk_err", 64'(bus.stk_err), 64'h0);

    //   mfc  flags    cc       map    upc    ctrl
    add(1'b0, 4'b0000, 4'hE, 6'h00, 6'h00, 8'h05);
    add(1'b0, 4'b0000, 4'hE, 6'h00, 6'h01, 8'h11);
    add(1'b0, 4'b0000, 4'hE, 6'h00, 6'h02, 8'h22);
    add(1'b0, 4'b0000, 4'hE, 6'h00, 6'h02, 8'h22);
    add(1'b0, 4'b0000, 4'hE, 6'h00, 6'h02, 8'h22);
    add(1'b0, 4'b0000, 4'hE, 6'h00, 6'h02, 8'h22);
    add(1'b1, 4'b0000, 4'hE, 6'h00, 6'h03, 8'h33);
    add(1'b0, 4'b0100, 4'h0, 6'h00, 6'h20, 8'h20);
    add(1'b0, 4'b0100, 4'h0, 6'h00, 6'h03, 8'h33);
    add(1'b0, 4'b0000, 4'h0, 6'h00, 6'h04, 8'h44);
    add(1'b0, 4'b0100, 4'hE, 6'h10, 6'h10, 8'h10);
    add(1'b0, 4'b0000, 4'hE, 6'h10, 6'h04, 8'h44);
    add(1'b0, 4'b0000, 4'hE, 6'h10, 6'h05, 8'h55);
    add(1'b0, 4'b0000, 4'hE, 6'h10, 6'h06, 8'h66);
    add(1'b0, 4'b0000, 4'hE, 6'h3F, 6'h3F, 8'h3F);
    add(1'b0, 4'b0000, 4'hE, 6'h3F, 6'h00, 8'h05);
    add(1'b0, 4'b0000, 4'hE, 6'h3F, 6'h01, 8'h11);
    add(1'b1, 4'b0000, 4'hE, 6'h3F, 6'h02, 8'h22);
    add(1'b1, 4'b0000, 4'hE, 6'h3F, 6'h03, 8'h33);
    add(1'b0, 4'b0100, 4'hF, 6'h3F, 6'h04, 8'h44);
    add(1'b0, 4'b0000, 4'hE, 6'h3F, 6'h05, 8'h55);
    add(1'b0, 4'b0000, 4'hE, 6'h3F, 6'h06, 8'h66);
    add(1'b0, 4'b0000, 4'hE, 6'h08, 6'h08, 8'h08);

    ct[0]  = '{4'h0, 4'b0100, 1'b1};
    ct[1]  = '{4'h1, 4'b0100, 1'b0};
    ct[2]  = '{4'h2, 4'b0010, 1'b1};
    ct[3]  = '{4'h3, 4'b0010, 1'b0};
    ct[4]  = '{4'h4, 4'b1000, 1'b1};
    ct[5]  = '{4'h5, 4'b1000, 1'b0};
    ct[6]  = '{4'h6, 4'b0001, 1'b1};
    ct[7]  = '{4'h7, 4'b0000, 1'b1};
    ct[8]  = '{4'h8, 4'b0010, 1'b1};
    ct[9]  = '{4'h8, 4'b0110, 1'b0};
    ct[10] = '{4'h9, 4'b0110, 1'b1};
    ct[11] = '{4'h9, 4'b0010, 1'b0};
    ct[12] = '{4'hA, 4'b1001, 1'b1};
    ct[13] = '{4'hA, 4'b1000, 1'b0};
    ct[14] = '{4'hB, 4'b1000, 1'b1};
    ct[15] = '{4'hC, 4'b1101, 1'b0};
    ct[16] = '{4'hC, 4'b0000, 1'b1};
    ct[17] = '{4'hD, 4'b0000, 1'b0};
    ct[18] = '{4'hD, 4'b1000, 1'b1};
    ct[19] = '{4'hE, 4'b0000, 1'b1};
    ct[20] = '{4'hF, 4'b1111, 1'b0};
    for (int k = 0; k < 21; k++) begin
      add(1'b0, ct[k].fl, ct[k].cc, 6'h08, ct[k].pass ? 6'h28 : 6'h09,
          ct[k].pass ? 8'h28 : 8'h09);
      add(1'b0, ct[k].fl, ct[k].cc, 6'h08, 6'h08, 8'h08);
    end

    CLR = 1'b1;
    foreach (vt[i]) begin
      bus.mfc      = vt[i].mfc;
      bus.flags    = vt[i].fl;
      bus.ir       = {vt[i].cc, 28'h0ABCDEF};
      bus.map_addr = vt[i].map;
      step();
      check($sformatf("v%0d upc", i), 64'(bus.upc), 64'(vt[i].exp_upc));
      check($sformatf("v%0d ctrl_out", i), 64'(bus.ctrl_out), 64'(vt[i].exp_ctrl));
    end
    check("program A stk_err", 64'(bus.stk_err), 64'h0);

    // Program B: five nested CALLs on a 4-deep stack, then LIFO unwind
    CLR = 1'b0;
    bus.ir = {4'hE, 28'h0};
    load(6'h00, mw(3'd3, 2'd0, 1'b0, 6'h30, 8'h00));
    load(6'h30, mw(3'd6, 2'd0, 1'b0, 6'h32, 8'h30));
    load(6'h31, mw(3'd7, 2'd0, 1'b0, 6'h00, 8'h31));
    load(6'h32, mw(3'd6, 2'd0, 1'b0, 6'h34, 8'h32));
    load(6'h33, mw(3'd7, 2'd0, 1'b0, 6'h00, 8'h33));
    load(6'h34, mw(3'd6, 2'd0, 1'b0, 6'h36, 8'h34));
    load(6'h35, mw(3'd7, 2'd0, 1'b0, 6'h00, 8'h35));
    load(6'h36, mw(3'd6, 2'd0, 1'b0, 6'h38, 8'h36));
    load(6'h37, mw(3'd7, 2'd0, 1'b0, 6'h00, 8'h37));
    load(6'h38, mw(3'd6, 2'd0, 1'b0, 6'h3A, 8'h38));
    load(6'h3A, mw(3'd7, 2'd0, 1'b0, 6'h00, 8'h3A));
    s_upc = '{6'h00, 6'h30, 6'h32, 6'h34, 6'h36, 6'h38, 6'h3A,
              6'h37, 6'h35, 6'h33, 6'h31, 6'h00, 6'h30};
    s_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    CLR = 1'b1;
    for (int e = 0; e < 13; e++) begin
      step();
      check($sformatf("stack e%0d upc", e + 1), 64'(bus.upc), 64'(s_upc[e]));
      check($sformatf("stack e%0d stk_err", e + 1), 64'(bus.stk_err), 64'(s_err[e]));
    end

    // Reset with two entries on the stack, then RET must see an empty stack
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    step();
    step();
    step();
    step();
    check("mid-call upc", 64'(bus.upc), 64'h34);
    CLR = 1'b0;
    #1;
    check("mid-call reset upc", 64'(bus.upc), 64'h0);
    check("mid-call reset ctrl_out", 64'(bus.ctrl_out), 64'h0);
    check("mid-call reset stk_err", 64'(bus.stk_err), 64'h0);
    load(6'h00, mw(3'd7, 2'd0, 1'b0, 6'h15, 8'h07));
    CLR = 1'b1;
    step();
    check("underflow e1 upc", 64'(bus.upc), 64'h0);
    check("underflow e1 ctrl_out", 64'(bus.ctrl_out), 64'h07);
    check("underflow e1 stk_err", 64'(bus.stk_err), 64'h0);
    step();
    check("underflow e2 upc", 64'(bus.upc), 64'h0);
    check("underflow e2 stk_err", 64'(bus.stk_err), 64'h1);

    // Program D: overwrite store[upc+1] on the edge that fetches it
    CLR = 1'b0;
    load(6'h00, mw(3'd2, 2'd0, 1'b0, 6'h00, 8'h01));
    load(6'h01, mw(3'd2, 2'd0, 1'b0, 6'h00, 8'hA1));
    load(6'h02, mw(3'd3, 2'd0, 1'b0, 6'h00, 8'hA2));
    CLR = 1'b1;
    step();
    check("collide e1 upc", 64'(bus.upc), 64'h0);
    check("collide e1 ctrl_out", 64'(bus.ctrl_out), 64'h01);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 6'h01;
    bus.ld_data = mw(3'd3, 2'd0, 1'b0, 6'h00, 8'hB1);
    step();
    bus.ld_en = 1'b0;
    check("collide e2 upc", 64'(bus.upc), 64'h1);
    check("collide e2 old word", 64'(bus.ctrl_out), 64'hA1);
    step();
    check("collide e3 upc", 64'(bus.upc), 64'h2);
    check("collide e3 ctrl_out", 64'(bus.ctrl_out), 64'hA2);
    step();
    check("collide e4 upc", 64'(bus.upc), 64'h0);
    step();
    check("collide e5 upc", 64'(bus.upc), 64'h1);
    check("collide e5 new word", 64'(bus.ctrl_out), 64'hB1);
    step();
    check("collide e6 upc", 64'(bus.upc), 64'h0);
    check("collide stk_err", 64'(bus.stk_err), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter SW, 6, microaddress (state) width; control store depth is 2**SW.
REQ-002 Parameter CW, 45, width of the datapath control field.
REQ-003 Parameter STK, 4, return-stack depth; legal range 1..16.
REQ-004 Clock clk; reset CLR, asynchronous, active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 CLR  in  1  asynchronous active-low reset.
REQ-007 ir  in  32  instruction register; ir[31:28] is the condition field.
REQ-008 flags  in  4  status flags {N,Z,C,V}, with N at bit 3.
REQ-009 mfc  in  1  memory-function-complete.
REQ-010 map_addr  in  SW  entry microaddress from the external instruction decoder.
REQ-011 ld_en  in  1  control-store write strobe.
REQ-012 ld_addr  in  SW  control-store write address.
REQ-013 ld_data  in  CW+SW+6  microword to write.
REQ-014 ctrl_out  out  CW  control field of the current microword.
REQ-015 upc  out  SW  current microaddress.
REQ-016 stk_err  out  1  sticky stack overflow/underflow flag.

Function
REQ-017 Microword layout, MSB to LSB: mode[2:0], csel[1:0], inv, target[SW-1:0], ctrl[CW-1:0].
REQ-018 Registered microinstruction register (MIR): on each rising clk, upc <= next and MIR <= store[next]; ctrl_out = MIR.ctrl, so control-field latency is one cycle after the address is chosen.
REQ-019 cond = inv XOR sel, where sel is chosen by csel: 00 mfc, 01 cpass, 10 1, 11 flags Z.
REQ-020 cpass uses the ARM table on ir[31:28]: EQ, NE, CS, CC, MI, PL, VS, VC, HI(C&~Z), LS(~C|Z), GE(N==V), LT(N!=V), GT(~Z&N==V), LE(Z|N!=V), 1110 always, 1111 never.
REQ-021 mode 000 ZERO: next = 0.
REQ-022 mode 001 MAP: next = map_addr.
REQ-023 mode 010 INC: next = upc+1, modulo 2**SW with wrap-around.
REQ-024 mode 011 JMP: next = target.
REQ-025 mode 100 CJMP: next = cond ? target : upc+1.
REQ-026 mode 101 CMAP: next = cond ? map_addr : upc+1.
REQ-027 mode 110 CALL: push upc+1, then next = target; if the stack is full, no push, stk_err <= 1, and the jump is still taken.
REQ-028 mode 111 RET: next = pop; if the stack is empty, next = 0 and stk_err <= 1.
REQ-029 MFC wait idiom: CJMP with target = own address, csel = 00, inv = 1; the sequencer holds upc until mfc = 1 and advances on the first edge that samples mfc high.
REQ-030 Store write: when ld_en = 1, store[ld_addr] <= ld_data on the rising edge. A read at the same address in the same edge returns the old data. The write does not stall sequencing.
REQ-031 stk_err is cleared only by reset.

Reset
REQ-032 CLR low: upc = 0, MIR = all-zero, ctrl_out = 0, stack pointer = 0 (empty), stk_err = 0.
REQ-033 Control-store contents are not affected by reset.
REQ-034 An all-zero MIR decodes as ZERO, so the first edge after reset release fetches store[0].
REQ-035 A reset mid-CALL/RET discards stack contents.

Structure
REQ-036 A shared package holds the mode encodings, the csel encodings, the ARM condition codes, and the microword field-offset constants derived from SW and CW.
REQ-037 Sub-module cond_eval (combinational ARM condition check); the return stack stays inline.

Verification
REQ-038 Reset; store[0] = INC with ctrl = 0x5; release CLR -> after edge 1, upc = 0 and ctrl_out = 0x5; after edge 2, upc = 1.
REQ-039 store[2] = CJMP to 2, csel = 00, inv = 1; hold mfc = 0 for 3 cycles, then 1 -> upc stays 2 for 3 edges, then becomes 3.
REQ-040 ir[31:28] = 0000 with flags = 0100, CJMP csel = 01 to 0x20 -> upc = 0x20; with flags = 0000 -> upc = upc+1.
REQ-041 STK = 4; five nested CALLs -> stk_err = 1 after the 5th, and upc = 5th target; four RETs unwind in LIFO order.
REQ-042 RET on empty stack -> upc = 0, stk_err = 1; INC at address 2**SW-1 -> upc = 0.
REQ-043 ld_en writes store[upc+1] in the same cycle as the fetch of upc+1 -> the old word executes; the new word executes on the next visit.
